// File: rtl/fp_cmp_pkg.sv
// Shared constants and helpers for the FloPoCo-format compare pipeline.
// Op codes, exception codes and operand width helper.
package fp_cmp_pkg;

  localparam logic [2:0] CMP_EQ = 3'd0;
  localparam logic [2:0] CMP_NE = 3'd1;
  localparam logic [2:0] CMP_LT = 3'd2;
  localparam logic [2:0] CMP_LE = 3'd3;
  localparam logic [2:0] CMP_GT = 3'd4;
  localparam logic [2:0] CMP_GE = 3'd5;

  localparam logic [1:0] EXC_ZERO   = 2'b00;
  localparam logic [1:0] EXC_NORMAL = 2'b01;
  localparam logic [1:0] EXC_INF    = 2'b10;
  localparam logic [1:0] EXC_NAN    = 2'b11;

  function automatic int fp_w(input int we, input int wf);
    return we + wf + 3;
  endfunction

endpackage

// File: rtl/fp_cmp_lane.sv
// One compare lane: stage-1 key register, stage-2 relation logic.
// Result is combinational from the stage-1 registers.
module fp_cmp_lane
  import fp_cmp_pkg::*;
#(
  parameter int WE = 11,
  parameter int WF = 8,
  localparam int W  = fp_w(WE, WF),
  localparam int MW = WE + WF + 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic         res,
  output logic         unord
);

  logic [MW-1:0] ma, mb;
  logic          sa, sb;
  logic [2:0]    op_q;
  logic          nan_a, nan_b, bz;
  logic          eq, lt, rel;

  // Zero and infinity keys ignore exp/frac so junk payloads compare equal.
  function automatic logic [MW-1:0] mkey(input logic [W-1:0] x);
    logic [1:0] e;
    e = x[W-1 -: 2];
    if (e == EXC_ZERO || e == EXC_INF)
      return {e, {(MW-2){1'b0}}};
    return {e, x[W-4:0]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      ma    <= '0;
      mb    <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      op_q  <= '0;
      nan_a <= 1'b0;
      nan_b <= 1'b0;
      bz    <= 1'b0;
    end else if (en) begin
      ma    <= mkey(a);
      mb    <= mkey(b);
      sa    <= a[W-3];
      sb    <= b[W-3];
      op_q  <= op;
      nan_a <= (a[W-1 -: 2] == EXC_NAN);
      nan_b <= (b[W-1 -: 2] == EXC_NAN);
      bz    <= (a[W-1 -: 2] == EXC_ZERO)
            && (b[W-1 -: 2] == EXC_ZERO);
    end
  end

  always_comb begin
    eq = bz || (sa == sb && ma == mb);
    if (sa != sb && !bz)
      lt = sa;
    else if (!sa)
      lt = (ma < mb);
    else
      lt = (ma > mb);
    rel = 1'b0;
    case (op_q)
      CMP_EQ:  rel = eq;
      CMP_NE:  rel = !eq;
      CMP_LT:  rel = lt;
      CMP_LE:  rel = lt || eq;
      CMP_GT:  rel = !(lt || eq);
      CMP_GE:  rel = !lt;
      default: rel = 1'b0;
    endcase
    unord = nan_a || nan_b;
    res   = unord ? (op_q == CMP_NE) : rel;
  end

endmodule

// File: rtl/fp_compare_pipe.sv
// Multi-lane pipelined FP comparator, two register stages.
// Elastic valid/ready pipeline; output register holds under stall.
module fp_compare_pipe
  import fp_cmp_pkg::*;
#(
  parameter int WE    = 11,
  parameter int WF    = 8,
  parameter int LANES = 3,
  parameter int TAG_W = 4,
  localparam int W    = fp_w(WE, WF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] in_a,
  input  logic [LANES*W-1:0] in_b,
  input  logic [LANES*3-1:0] in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES-1:0]   out_res,
  output logic [LANES-1:0]   out_unord,
  output logic               out_all,
  output logic [TAG_W-1:0]   out_tag
);

  logic             s1_valid, s2_valid;
  logic             s1_en, s2_en, load;
  logic [TAG_W-1:0] s1_tag;
  logic [LANES-1:0] res_d, unord_d;

  assign s2_en     = !s2_valid || out_ready;
  assign s1_en     = !s1_valid || s2_en;
  assign in_ready  = s1_en;
  assign load      = in_valid && s1_en;
  assign out_valid = s2_valid;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fp_cmp_lane #(
      .WE(WE),
      .WF(WF)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .en    (load),
      .a     (in_a[i*W +: W]),
      .b     (in_b[i*W +: W]),
      .op    (in_op[i*3 +: 3]),
      .res   (res_d[i]),
      .unord (unord_d[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s1_tag    <= '0;
      out_res   <= '0;
      out_unord <= '0;
      out_all   <= 1'b0;
      out_tag   <= '0;
    end else begin
      if (s1_en) begin
        s1_valid <= in_valid;
        if (in_valid) s1_tag <= in_tag;
      end
      if (s2_en) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_res   <= res_d;
          out_unord <= unord_d;
          out_all   <= &res_d;
          out_tag   <= s1_tag;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Scoreboard bench for fp_compare_pipe: directed cases plus random
// regression against a signed-ordinal reference model.
module tb_fp_compare_pipe;

  localparam int WE = 11;
  localparam int WF = 8;
  localparam int L  = 3;
  localparam int TW = 4;
  localparam int W  = WE + WF + 3;

  localparam logic [W-1:0] ONE  = 22'h13FF00;
  localparam logic [W-1:0] TWO  = 22'h140000;
  localparam logic [W-1:0] NEG1 = 22'h1BFF00;
  localparam logic [W-1:0] PZ   = 22'h000000;
  localparam logic [W-1:0] NZ   = 22'h080000;
  localparam logic [W-1:0] INF  = 22'h200000;
  localparam logic [W-1:0] NAN  = 22'h300000;

  localparam logic [2:0] EQ = 3'd0, NE = 3'd1, LT = 3'd2;
  localparam logic [2:0] LE = 3'd3, GT = 3'd4, GE = 3'd5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [L*W-1:0] in_a = '0;
  logic [L*W-1:0] in_b = '0;
  logic [L*3-1:0] in_op = '0;
  logic [TW-1:0]  in_tag = '0;
  logic           out_valid;
  logic           out_ready;
  logic [L-1:0]   out_res;
  logic [L-1:0]   out_unord;
  logic           out_all;
  logic [TW-1:0]  out_tag;

  fp_compare_pipe #(
    .WE(WE), .WF(WF), .LANES(L), .TAG_W(TW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_unord(out_unord),
    .out_all(out_all), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [L-1:0]  res;
    logic [L-1:0]  unord;
    logic          all;
    logic [TW-1:0] tag;
    int            cyc;
    bit            lat;
  } item_t;

  item_t sbq[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int stall_seen = 0;
  int rdy_mode = 0;
  int t0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Ordinal value on the real line: zeros collapse, inf is above all normals.
  function automatic longint fval(input logic [W-1:0] x);
    longint r;
    longint ex;
    longint fr;
    ex = longint'(x[WE+WF-1:WF]);
    fr = longint'(x[WF-1:0]);
    case (x[W-1:W-2])
      2'b00:   r = 0;
      2'b01:   r = 1 + ex * (longint'(1) << WF) + fr;
      2'b10:   r = longint'(1) << (WE + WF + 1);
      default: r = 0;
    endcase
    return x[W-3] ? -r : r;
  endfunction

  // Returns {unord, res}.
  function automatic logic [1:0] ref_lane(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic [2:0] op);
    longint va, vb;
    logic r;
    if (a[W-1:W-2] == 2'b11 || b[W-1:W-2] == 2'b11)
      return {1'b1, op == NE};
    va = fval(a);
    vb = fval(b);
    case (op)
      EQ:      r = (va == vb);
      NE:      r = (va != vb);
      LT:      r = (va < vb);
      LE:      r = (va <= vb);
      GT:      r = (va > vb);
      GE:      r = (va >= vb);
      default: r = 1'b0;
    endcase
    return {1'b0, r};
  endfunction

  function automatic logic [W-1:0] rnd_fp();
    logic [1:0]    e;
    logic          s;
    logic [WE-1:0] ex;
    logic [WF-1:0] f;
    int k;
    k = $urandom_range(0, 9);
    e = (k == 0) ? 2'b00 : (k == 1) ? 2'b10 : (k == 2) ? 2'b11 : 2'b01;
    s = 1'($urandom);
    ex = $urandom_range(0, 1) ? WE'(11'h3FE + $urandom_range(0, 2))
                              : WE'($urandom);
    f = $urandom_range(0, 1) ? WF'($urandom_range(0, 2)) : WF'($urandom);
    return {e, s, ex, f};
  endfunction

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       out_ready = ($urandom_range(0, 3) != 0);
        2:       out_ready = !(cyc >= t0 + 3 && cyc <= t0 + 5);
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic send(input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                      input logic [L*3-1:0] op, input logic [TW-1:0] tag,
                      input logic [L-1:0] er, input logic [L-1:0] eu,
                      input bit lat);
    bit ok;
    int guard;
    item_t it;
    ok = 1'b0;
    guard = 0;
    in_a = a;
    in_b = b;
    in_op = op;
    in_tag = tag;
    in_valid = 1'b1;
    while (!ok) begin
      ok = in_ready;
      if (ok) begin
        it.res = er;
        it.unord = eu;
        it.all = &er;
        it.tag = tag;
        it.cyc = cyc;
        it.lat = lat;
        sbq.push_back(it);
      end else begin
        stall_seen++;
      end
      @(posedge clk);
      @(negedge clk);
      guard++;
      if (!ok && guard > 1000) begin
        chk("in_ready_timeout", 0, 1);
        ok = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [L*W-1:0] a,
                            input logic [L*W-1:0] b,
                            input logic [L*3-1:0] op,
                            input logic [TW-1:0] tag);
    logic [L-1:0] er, eu;
    logic [1:0] r;
    for (int l = 0; l < L; l++) begin
      r = ref_lane(a[l*W +: W], b[l*W +: W], op[l*3 +: 3]);
      eu[l] = r[1];
      er[l] = r[0];
    end
    send(a, b, op, tag, er, eu, 1'b0);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sbq.size() != 0 && g < 500) begin
      idle(1);
      g++;
    end
    chk("drain_empty", sbq.size(), 0);
  endtask

  // Monitor: pop and compare on each output handshake, check hold on stall.
  initial begin
    bit held;
    logic [2*L+TW:0] snap, cur;
    item_t it;
    held = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk);
      #1;
      cur = {out_res, out_unord, out_all, out_tag};
      if (!rst && out_valid) begin
        if (held) chk("stall_hold", cur, snap);
        if (!out_ready) begin
          held = 1'b1;
          snap = cur;
        end else begin
          held = 1'b0;
          if (sbq.size() == 0) begin
            chk("unexpected_out", 1, 0);
          end else begin
            it = sbq.pop_front();
            chk("result", cur, {it.res, it.unord, it.all, it.tag});
            if (it.lat) chk("latency", cyc, it.cyc + 2);
          end
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    logic [L*W-1:0] ra, rb;
    logic [L*3-1:0] rop;
    logic [W-1:0] x;
    logic [2:0] o;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_valid", out_valid, 0);
    chk("reset_ready", in_ready, 1);
    chk("reset_outs", {out_res, out_unord, out_all, out_tag}, 0);

    send({ONE, NEG1, TWO}, {ONE, ONE, ONE}, {EQ, LT, GE}, 4'd1,
         3'b111, 3'b000, 1'b1);
    idle(3);
    send({NEG1, PZ, PZ}, {NZ, NZ, NZ}, {LT, GT, EQ}, 4'd2,
         3'b101, 3'b000, 1'b1);
    send({NZ, INF, INF}, {PZ, INF, TWO}, {GE, EQ, GT}, 4'd3,
         3'b111, 3'b000, 1'b1);
    for (int k = 0; k < 8; k++) begin
      o = 3'(k);
      send({NAN, ONE, NAN}, {ONE, NAN, ONE}, {o, o, o}, 4'(k),
           (o == NE) ? 3'b111 : 3'b000, 3'b111, 1'b1);
    end
    drain();

    t0 = cyc;
    rdy_mode = 2;
    stall_seen = 0;
    for (int k = 0; k < 8; k++)
      send_model({TWO, ONE, NEG1}, {ONE, TWO, NZ},
                 {3'(k % 6), LE, 3'((k + 2) % 6)}, 4'(k));
    drain();
    rdy_mode = 0;
    chk("burst_stall_cycles", stall_seen, 3);

    send_model({ONE, ONE, ONE}, {TWO, TWO, TWO}, {LT, LT, LT}, 4'd9);
    send_model({TWO, TWO, TWO}, {ONE, ONE, ONE}, {GT, GT, GT}, 4'd10);
    rst = 1'b1;
    sbq.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_outs", {out_res, out_unord, out_all, out_tag}, 0);
    chk("midrst_ready", in_ready, 1);
    rst = 1'b0;
    idle(6);
    chk("midrst_no_stale", out_valid, 0);

    rdy_mode = 1;
    for (int n = 0; n < 3400; n++) begin
      for (int l = 0; l < L; l++) begin
        x = rnd_fp();
        ra[l*W +: W] = x;
        case ($urandom_range(0, 5))
          0:       rb[l*W +: W] = x;
          1:       rb[l*W +: W] = {x[W-1:W-2], ~x[W-3], x[W-4:0]};
          default: rb[l*W +: W] = rnd_fp();
        endcase
        rop[l*3 +: 3] = 3'($urandom_range(0, 7));
      end
      send_model(ra, rb, rop, 4'($urandom));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
